// File: rtl/gpu_dma_pkg.sv
// Shared types and VRAM region map for the GPU block-copy engine.
package gpu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dma_state_t;

  localparam int VRAM_ADDR_WIDTH = 12;

  localparam logic [VRAM_ADDR_WIDTH-1:0] VRAM_PMF_BASE = 12'h000;
  localparam logic [VRAM_ADDR_WIDTH-1:0] VRAM_OBM_BASE = 12'h800;
  localparam int                         VRAM_OBM_SIZE = 256;

endpackage

// File: rtl/vram_dma.sv
// Copies a block from synchronous work RAM into VRAM one byte per cycle,
// pausing whenever the video timing closes the VRAM write window.
module vram_dma
  import gpu_dma_pkg::*;
#(
  parameter int MAX_LEN = 512,
  parameter int SRC_AW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SRC_AW-1:0]          src_base,
  input  logic [VRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [$clog2(MAX_LEN):0]   length,
  input  logic                       writable,
  output logic [SRC_AW-1:0]          src_addr,
  output logic                       src_re,
  input  logic [7:0]                 src_data,
  output logic [7:0]                 data_out,
  output logic [VRAM_ADDR_WIDTH-1:0] address,
  output logic                       write_enable,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  dma_state_t                 state_q;
  logic [SRC_AW-1:0]          rd_ptr_q;
  logic [VRAM_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [LEN_W-1:0]           rd_left_q;
  logic [LEN_W-1:0]           wr_left_q;
  logic                       pending_q;
  logic                       hold_valid_q;
  logic [7:0]                 hold_q;

  logic rd_go;
  logic wr_go;
  logic skid;

  // A read may only issue when its byte can be written next cycle, so at
  // most one byte is ever in flight and a single holding register suffices.
  assign rd_go = (state_q == RUN) && writable && (rd_left_q != '0)
                 && !(pending_q && !writable);
  assign wr_go = pending_q && writable;
  assign skid  = pending_q && !writable && !hold_valid_q;

  assign src_re       = rd_go;
  assign src_addr     = rd_ptr_q;
  assign write_enable = wr_go;
  assign address      = wr_ptr_q;
  assign data_out     = pending_q ? (hold_valid_q ? hold_q : src_data) : 8'h00;
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_left_q    <= '0;
      wr_left_q    <= '0;
      pending_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_ptr_q  <= src_base;
            wr_ptr_q  <= dst_base;
            rd_left_q <= length;
            wr_left_q <= length;
            state_q   <= (length != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (rd_go) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_left_q <= rd_left_q - 1'b1;
          end
          if (wr_go) begin
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            wr_left_q <= wr_left_q - 1'b1;
            if (wr_left_q == LEN_W'(1)) state_q <= DONE;
          end
          pending_q <= rd_go || (pending_q && !wr_go);
          // Source data is only valid the cycle after the read, so park it.
          if (skid) begin
            hold_q       <= src_data;
            hold_valid_q <= 1'b1;
          end else if (wr_go) begin
            hold_valid_q <= 1'b0;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          pending_q    <= 1'b0;
          hold_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_dma.sv
// Directed bench for vram_dma: block copies, stalls, zero length, restart, reset, wrap.
module tb_vram_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [11:0] dst_base = '0;
  logic [9:0]  length = '0;
  logic        writable = 1'b1;
  logic [15:0] src_addr;
  logic        src_re;
  logic [7:0]  src_data = 8'h00;
  logic [7:0]  data_out;
  logic [11:0] address;
  logic        write_enable;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [7:0]  smem [0:65535];
  logic        obs_re   [0:600];
  logic        obs_we   [0:600];
  logic        obs_busy [0:600];
  logic        obs_done [0:600];
  logic [11:0] wa [0:600];
  logic [7:0]  wd [0:600];
  int          wc [0:600];
  int          nw, done_cyc, done_cnt;

  vram_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .length(length), .writable(writable), .src_addr(src_addr), .src_re(src_re),
    .src_data(src_data), .data_out(data_out), .address(address),
    .write_enable(write_enable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (src_re) src_data <= smem[src_addr];

  function automatic logic [7:0] sbyte(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic run_xfer(input logic [15:0] s, input logic [11:0] d, input logic [9:0] l,
                          input int st_lo, input int st_hi, input int rs_cyc, input int ncyc);
    nw = 0; done_cyc = 0; done_cnt = 0;
    @(posedge clk); #1;
    src_base = s; dst_base = d; length = l; start = 1'b1; writable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      writable = !(k >= st_lo && k <= st_hi);
      if (k == rs_cyc) begin
        start = 1'b1; src_base = 16'h4000; dst_base = 12'h100; length = 10'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      obs_re[k] = src_re; obs_we[k] = write_enable;
      obs_busy[k] = busy; obs_done[k] = done;
      if (write_enable && nw < 600) begin
        wa[nw] = address; wd[nw] = data_out; wc[nw] = k; nw++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = k;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; writable = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({src_re, src_addr, data_out, address, write_enable, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: re=%b sa=%h do=%h ad=%h we=%b busy=%b done=%b, want all 0",
               src_re, src_addr, data_out, address, write_enable, busy, done);
    end
    @(posedge clk); #1;
    start = 1'b1; length = 10'd5; src_base = 16'h0000; dst_base = 12'h010;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, src_re, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_wins_over_start: busy=%b re=%b done=%b, want 000", busy, src_re, done);
    end
  endtask

  task automatic test_obm_copy;
    run_xfer(16'h0000, 12'h800, 10'd256, 0, -1, 0, 262);
    tests++;
    if (nw !== 256) begin fails++; $display("FAIL obm_write_count: got %0d want 256", nw); end
    for (int n = 0; n < 256 && n < nw; n++) begin
      tests++;
      if (wa[n] !== 12'h800 + 12'(n) || wd[n] !== 8'(n) || wc[n] !== n + 2) begin
        fails++;
        $display("FAIL obm_write[%0d]: addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 n, wa[n], wd[n], wc[n], 12'h800 + 12'(n), 8'(n), n + 2);
      end
    end
    for (int k = 1; k <= 262; k++) begin
      tests++;
      if ({obs_re[k], obs_we[k], obs_busy[k], obs_done[k]} !==
          {k <= 256, k >= 2 && k <= 257, k <= 257, k == 258}) begin
        fails++;
        $display("FAIL obm_timing cyc %0d: re/we/busy/done=%b%b%b%b want %b%b%b%b", k,
                 obs_re[k], obs_we[k], obs_busy[k], obs_done[k],
                 k <= 256, k >= 2 && k <= 257, k <= 257, k == 258);
      end
    end
  endtask

  task automatic test_stall;
    int exp_c;
    run_xfer(16'h0000, 12'h800, 10'd256, 50, 70, 0, 285);
    tests++;
    if (nw !== 256) begin fails++; $display("FAIL stall_write_count: got %0d want 256", nw); end
    for (int n = 0; n < 256 && n < nw; n++) begin
      exp_c = (n + 2 < 50) ? n + 2 : n + 23;
      tests++;
      if (wa[n] !== 12'h800 + 12'(n) || wd[n] !== 8'(n) || wc[n] !== exp_c) begin
        fails++;
        $display("FAIL stall_write[%0d]: addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                 n, wa[n], wd[n], wc[n], 12'h800 + 12'(n), 8'(n), exp_c);
      end
    end
    for (int k = 1; k <= 285; k++) begin
      tests++;
      if ({obs_re[k], obs_we[k]} !==
          {(k <= 49) || (k >= 71 && k <= 277), (k >= 2 && k <= 49) || (k >= 71 && k <= 278)}) begin
        fails++;
        $display("FAIL stall_timing cyc %0d: re/we=%b%b want %b%b", k, obs_re[k], obs_we[k],
                 (k <= 49) || (k >= 71 && k <= 277), (k >= 2 && k <= 49) || (k >= 71 && k <= 278));
      end
    end
    tests++;
    if (done_cyc !== 279 || done_cnt !== 1) begin
      fails++;
      $display("FAIL stall_done: cyc=%0d count=%0d want cyc=279 count=1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_zero_len;
    int re_cnt, busy_cnt;
    run_xfer(16'h0123, 12'h123, 10'd0, 0, -1, 0, 6);
    re_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (obs_re[k]) re_cnt++;
      if (obs_busy[k]) busy_cnt++;
    end
    tests++;
    if (done_cyc !== 1 || done_cnt !== 1) begin
      fails++;
      $display("FAIL zero_len_done: cyc=%0d count=%0d want cyc=1 count=1", done_cyc, done_cnt);
    end
    tests++;
    if (re_cnt !== 0 || nw !== 0 || busy_cnt !== 0) begin
      fails++;
      $display("FAIL zero_len_quiet: reads=%0d writes=%0d busy=%0d want 0 0 0", re_cnt, nw, busy_cnt);
    end
  endtask

  task automatic test_restart_ignored;
    run_xfer(16'h0200, 12'h300, 10'd40, 0, -1, 20, 46);
    tests++;
    if (nw !== 40) begin fails++; $display("FAIL restart_write_count: got %0d want 40", nw); end
    for (int n = 0; n < 40 && n < nw; n++) begin
      tests++;
      if (wa[n] !== 12'h300 + 12'(n) || wd[n] !== sbyte(16'h0200 + 16'(n))) begin
        fails++;
        $display("FAIL restart_write[%0d]: addr=%h data=%h want addr=%h data=%h", n, wa[n], wd[n],
                 12'h300 + 12'(n), sbyte(16'h0200 + 16'(n)));
      end
    end
    tests++;
    if (done_cyc !== 42 || done_cnt !== 1) begin
      fails++;
      $display("FAIL restart_done: cyc=%0d count=%0d want cyc=42 count=1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int cnt, late;
    @(posedge clk); #1;
    src_base = 16'h0000; dst_base = 12'h800; length = 10'd64; start = 1'b1; writable = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cnt = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) rst = 1'b1;
      @(negedge clk);
      if (write_enable) cnt++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cnt !== 10) begin fails++; $display("FAIL reset_mid_writes: got %0d want 10", cnt); end
    tests++;
    if ({src_re, src_addr, data_out, address, write_enable, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: re=%b sa=%h do=%h ad=%h we=%b busy=%b done=%b, want all 0",
               src_re, src_addr, data_out, address, write_enable, busy, done);
    end
    late = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (done || write_enable || busy) late++;
    end
    tests++;
    if (late !== 0) begin fails++; $display("FAIL reset_mid_no_done: active cycles=%0d want 0", late); end
    run_xfer(16'h0040, 12'h500, 10'd8, 0, -1, 0, 12);
    tests++;
    if (nw !== 8 || done_cyc !== 10) begin
      fails++;
      $display("FAIL reset_mid_fresh: writes=%0d done_cyc=%0d want 8 10", nw, done_cyc);
    end
    for (int n = 0; n < 8 && n < nw; n++) begin
      tests++;
      if (wa[n] !== 12'h500 + 12'(n) || wd[n] !== sbyte(16'h0040 + 16'(n))) begin
        fails++;
        $display("FAIL reset_mid_fresh_write[%0d]: addr=%h data=%h want addr=%h data=%h", n, wa[n],
                 wd[n], 12'h500 + 12'(n), sbyte(16'h0040 + 16'(n)));
      end
    end
  endtask

  task automatic test_wrap;
    logic [11:0] exp_a [0:3];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    run_xfer(16'h0010, 12'hFFE, 10'd4, 0, -1, 0, 8);
    tests++;
    if (nw !== 4 || done_cyc !== 6) begin
      fails++;
      $display("FAIL wrap_count: writes=%0d done_cyc=%0d want 4 6", nw, done_cyc);
    end
    for (int n = 0; n < 4 && n < nw; n++) begin
      tests++;
      if (wa[n] !== exp_a[n] || wd[n] !== sbyte(16'h0010 + 16'(n))) begin
        fails++;
        $display("FAIL wrap_write[%0d]: addr=%h data=%h want addr=%h data=%h", n, wa[n], wd[n],
                 exp_a[n], sbyte(16'h0010 + 16'(n)));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) smem[i] = sbyte(16'(i));
    test_reset;
    test_obm_copy;
    test_stall;
    test_zero_len;
    test_restart_ignored;
    test_reset_mid;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
